// File: rtl/data_mem_responder.sv
// Memory-side responder for the multi-cycle core's load/store path: one request at a time,
// fixed response latency, byte/half/word access with extension, lane merging and alignment checks.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size_s,
  input  logic        se_s,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        misalign,
  output logic        busy
);

  localparam int         AW        = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          we_q, se_q, err_q;
  logic [1:0]    size_q;
  logic [AW+1:0] addr_q;
  logic [31:0]   wdata_q, rdata_q;

  logic [31:0]   mem [DEPTH_WORDS];

  logic          accept, req_err;
  logic          cur_we, cur_se, cur_err;
  logic [1:0]    cur_size;
  logic [AW+1:0] cur_addr;
  logic [31:0]   rd_word, load_val;
  logic [7:0]    lane_b;
  logic [15:0]   lane_h;
  logic          load_fire;
  logic [3:0]    st_be;
  logic [31:0]   st_data;
  logic          unused_addr;

  assign unused_addr = ^addr[31:AW+2];

  function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] lo);
    return (sz == 2'b11) || (sz == 2'b01 && lo[0]) || (sz == 2'b10 && lo != 2'b00);
  endfunction

  assign accept  = (state_q == S_IDLE) && req;
  assign req_err = is_misaligned(size_s, addr[1:0]);

  // In IDLE the incoming request is used directly so a zero-wait load can sample RAM on acceptance.
  assign cur_we   = (state_q == S_IDLE) ? we       : we_q;
  assign cur_se   = (state_q == S_IDLE) ? se_s     : se_q;
  assign cur_size = (state_q == S_IDLE) ? size_s   : size_q;
  assign cur_addr = (state_q == S_IDLE) ? addr[AW+1:0] : addr_q;
  assign cur_err  = (state_q == S_IDLE) ? req_err  : err_q;

  // State register, request capture and registered load result.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      se_q    <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= load_fire ? load_val : 32'd0;
      if (accept) begin
        err_q   <= req_err;
        we_q    <= we;
        se_q    <= se_s;
        size_q  <= size_s;
        addr_q  <= addr[AW+1:0];
        wdata_q <= wdata;
      end
    end
  end

  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned and infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          if (req_err || WAIT_CYCLES == 0) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ready    = (state_q == S_RESP);
    busy     = (state_q != S_IDLE);
    misalign = (state_q == S_RESP) && err_q;
    rdata    = rdata_q;
  end

  // Load path: read on the edge that enters RESP, so rdata is valid exactly with ready.
  assign load_fire = (state_d == S_RESP) && (state_q != S_RESP) && !cur_err && !cur_we;
  assign rd_word   = mem[cur_addr[AW+1:2]];
  assign lane_b    = rd_word[{cur_addr[1:0], 3'b000} +: 8];
  assign lane_h    = cur_addr[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    load_val = rd_word;
    unique case (cur_size)
      2'b00:   load_val = cur_se ? {24'd0, lane_b} : {{24{lane_b[7]}}, lane_b};
      2'b01:   load_val = cur_se ? {16'd0, lane_h} : {{16{lane_h[15]}}, lane_h};
      default: load_val = rd_word;
    endcase
  end

  always_comb begin
    st_be   = 4'b1111;
    st_data = wdata_q;
    unique case (size_q)
      2'b00: begin
        st_be   = 4'b0001 << addr_q[1:0];
        st_data = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        st_be   = addr_q[1] ? 4'b1100 : 4'b0011;
        st_data = {2{wdata_q[15:0]}};
      end
      default: begin
        st_be   = 4'b1111;
        st_data = wdata_q;
      end
    endcase
  end

  // Store commits on the edge ending RESP; a reset on that edge cancels it.
  always_ff @(posedge clk) begin
    // NOTE: the RAM array is deliberately not reset; contents survive rst.
    if (!rst && state_q == S_RESP && we_q && !err_q) begin
      for (int b = 0; b < 4; b++) begin
        if (st_be[b]) mem[addr_q[AW+1:2]][b*8 +: 8] <= st_data[b*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized self-checking bench for data_mem_responder against a byte-array memory model.
module tb_data_mem_responder;

  localparam int DEPTH_WORDS = 256;
  localparam int WAIT_CYCLES = 2;
  localparam int NBYTES      = 4 * DEPTH_WORDS;

  logic        clk = 1'b0;
  logic        rst, req, we, se_s;
  logic [1:0]  size_s;
  logic [31:0] addr, wdata, rdata;
  logic        ready, misalign, busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] model_mem [NBYTES];

  data_mem_responder #(.DEPTH_WORDS(DEPTH_WORDS), .WAIT_CYCLES(WAIT_CYCLES)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .size_s(size_s), .se_s(se_s),
    .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready), .misalign(misalign), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_err(input logic [1:0] sz, input logic [31:0] a);
    int ba = int'(a % 32'd4);
    if (sz == 2'd3) return 1'b1;
    if (sz == 2'd1) return (ba % 2) != 0;
    if (sz == 2'd2) return ba != 0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] sz, input logic s, input logic [31:0] a);
    int ba = int'(a % NBYTES);
    int v;
    if (sz == 2'd0) begin
      v = int'(model_mem[ba]);
      if (!s && v >= 128) v -= 256;
    end else if (sz == 2'd1) begin
      ba = ba - (ba % 2);
      v = int'(model_mem[ba]) + 256 * int'(model_mem[ba + 1]);
      if (!s && v >= 32768) v -= 65536;
    end else begin
      ba = ba - (ba % 4);
      return {model_mem[ba + 3], model_mem[ba + 2], model_mem[ba + 1], model_mem[ba]};
    end
    return 32'(v);
  endfunction

  task automatic model_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    int nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    int ba = int'(a % NBYTES);
    ba = ba - (ba % nb);
    for (int i = 0; i < nb; i++) model_mem[ba + i] = 8'((d >> (8 * i)) & 32'hFF);
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of the idle cycle after RESP.
  // poke_n > 0 pulses a stray store request in that cycle of the transaction, which must be ignored.
  task automatic txn(input logic w, input logic [1:0] sz, input logic s, input logic [31:0] a,
                     input logic [31:0] d, input int poke_n, input bit has_lit, input logic [31:0] lit);
    bit          e;
    int          exp_lat, lat;
    logic [31:0] exp_rd, got_rd;
    logic        got_mis;
    e       = model_err(sz, a);
    exp_rd  = (e || w) ? 32'd0 : model_load(sz, s, a);
    exp_lat = e ? 1 : WAIT_CYCLES + 1;
    lat     = 0;
    got_rd  = 32'd0;
    got_mis = 1'b0;
    req = 1'b1; we = w; size_s = sz; se_s = s; addr = a; wdata = d;
    @(posedge clk); #1 req = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (!ready) check("busy_hold", busy, 1'b1);
      if (n == poke_n) begin
        req = 1'b1; we = 1'b1; size_s = 2'd2; addr = $urandom & 32'hFFFF_FFFC; wdata = $urandom;
      end
      if (ready) begin
        lat = n; got_rd = rdata; got_mis = misalign;
        check("busy_resp", busy, 1'b1);
      end
      @(posedge clk); #1 req = 1'b0;
      if (lat != 0) break;
    end
    check("latency", lat, exp_lat);
    check("rdata", got_rd, exp_rd);
    check("misalign", got_mis, e);
    if (has_lit) check("rdata_lit", got_rd, lit);
    @(negedge clk);
    check("ready_pulse", ready, 1'b0);
    check("busy_after", busy, 1'b0);
    if (w && !e) model_store(sz, a, d);
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; we = 1'b0; size_s = 2'd0; se_s = 1'b0; addr = 32'd0; wdata = 32'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_rdata", rdata, 32'd0);
    check("rst_ready", ready, 1'b0);
    check("rst_misalign", misalign, 1'b0);
    check("rst_busy", busy, 1'b0);

    // Give every RAM word a known value.
    for (int i = 0; i < DEPTH_WORDS; i++) txn(1'b1, 2'd2, 1'b0, 32'(i * 4), $urandom, 0, 1'b0, 32'd0);

    txn(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 0, 1'b0, 32'd0);
    txn(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 0, 1'b1, 32'hDEADBEEF);
    txn(1'b0, 2'd0, 1'b0, 32'h13, 32'd0, 0, 1'b1, 32'hFFFFFFDE);
    txn(1'b0, 2'd0, 1'b1, 32'h13, 32'd0, 0, 1'b1, 32'h000000DE);
    txn(1'b0, 2'd1, 1'b0, 32'h12, 32'd0, 0, 1'b1, 32'hFFFFDEAD);
    txn(1'b0, 2'd1, 1'b1, 32'h10, 32'd0, 0, 1'b1, 32'h0000BEEF);
    txn(1'b1, 2'd0, 1'b0, 32'h11, 32'h00000055, 0, 1'b0, 32'd0);
    txn(1'b1, 2'd1, 1'b0, 32'h12, 32'h00001234, 0, 1'b0, 32'd0);
    txn(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 0, 1'b1, 32'h123455EF);
    txn(1'b0, 2'd2, 1'b0, 32'h12, 32'd0, 0, 1'b1, 32'd0);
    txn(1'b0, 2'd1, 1'b0, 32'h11, 32'd0, 0, 1'b1, 32'd0);
    txn(1'b0, 2'd3, 1'b0, 32'h00, 32'd0, 0, 1'b1, 32'd0);
    txn(1'b1, 2'd2, 1'b0, 32'h12, 32'hFFFFFFFF, 0, 1'b0, 32'd0);
    txn(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 1, 1'b1, 32'h123455EF);
    txn(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, WAIT_CYCLES + 1, 1'b1, 32'h123455EF);
    txn(1'b1, 2'd2, 1'b0, 32'h400, 32'hA5A5A5A5, 0, 1'b0, 32'd0);
    txn(1'b0, 2'd2, 1'b0, 32'h0, 32'd0, 0, 1'b1, 32'hA5A5A5A5);

    // Reset during WAIT aborts the store.
    txn(1'b1, 2'd2, 1'b0, 32'h20, 32'h22222222, 0, 1'b0, 32'd0);
    req = 1'b1; we = 1'b1; size_s = 2'd2; se_s = 1'b0; addr = 32'h20; wdata = 32'h11111111;
    @(posedge clk); #1 req = 1'b0;
    @(negedge clk);
    check("wait_busy", busy, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("abort_rdata", rdata, 32'd0);
    check("abort_ready", ready, 1'b0);
    check("abort_misalign", misalign, 1'b0);
    check("abort_busy", busy, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("abort_no_ready", ready, 1'b0);
    end
    txn(1'b0, 2'd2, 1'b0, 32'h20, 32'd0, 0, 1'b1, 32'h22222222);

    for (int i = 0; i < 300; i++) begin
      txn(1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom,
          int'($urandom_range(0, 4)), 1'b0, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder for the multi-cycle RISC-V core's load/store path: accepts one request, waits a parameterised latency, performs byte/half/word access on internal word RAM, returns a one-cycle `ready` pulse.
- Sits between the control unit's memory strobes (size from func3[1:0], extension from func3[2]) and the datapath's MDR.
- Also does load sign/zero extension, store byte-lane merging and alignment checking, so the datapath only holds a 32-bit MDR.

Parameters:
- DEPTH_WORDS, 256: number of 32-bit words in RAM; power of two, ≥4.
- WAIT_CYCLES, 2: extra cycles between acceptance and response; 0..15.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- req  input  1  request strobe, sampled only in IDLE.
- we  input  1  1 = store, 0 = load.
- size_s  input  2  00 byte, 01 half, 10 word, 11 illegal (= func3[1:0]).
- se_s  input  1  loads only: 0 sign-extend, 1 zero-extend (= func3[2]); ignored for stores.
- addr  input  32  byte address.
- wdata  input  32  store data, low bits used for byte/half.
- rdata  output  32  load result, valid while ready=1.
- ready  output  1  one-cycle completion pulse.
- misalign  output  1  error flag, valid with ready.
- busy  output  1  high from acceptance through the ready cycle.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-high, on rst.
- Reset values: rdata=0, ready=0, misalign=0, busy=0, FSM=IDLE, wait counter=0. RAM contents are not cleared.
- Reset mid-operation: the transaction is aborted, no RAM write occurs, and no ready is produced.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req=1 at edge T latches we, size_s, se_s, addr, wdata, and sets busy=1 from T+1.
  - If error → RESP.
  - Else if WAIT_CYCLES=0 → RESP.
  - Else → WAIT with counter=WAIT_CYCLES-1.
- Error condition (any of):
  - size_s=11
  - size_s=01 with addr[0]=1
  - size_s=10 with addr[1:0]≠00
- WAIT: counter decrements each cycle; at 0 → RESP.
- RESP (exactly one cycle):
  - ready=1. busy stays 1.
  - Next state is IDLE; busy=0 the cycle after.
- Latency: ready is asserted during cycle T+1+WAIT_CYCLES. Error responses always take one cycle (ready at T+1).
- Stores, non-error, in RESP:
  - RAM write occurs on the edge ending RESP. Only the addressed lanes are written.
  - Byte: lane addr[1:0] ← wdata[7:0].
  - Half: lanes addr[1]*2 and addr[1]*2+1 ← wdata[15:0].
  - Word: all lanes.
  - Little-endian. rdata=0 during a store response.
- Loads, non-error:
  - rdata is driven registered, valid in the RESP cycle.
  - Byte/half is selected from its lane, then extended per se_s.
  - Word ignores se_s.
- Error responses: misalign=1, rdata=0, no RAM write. misalign is 0 on all good responses.
- Address mapping: word index = addr[log2(DEPTH_WORDS)+1:2]. Upper bits are ignored, so addresses wrap modulo 4*DEPTH_WORDS.
- req while busy=1 (including the RESP cycle) is ignored, not queued. Requester must hold req deasserted until ready is seen.
- Back-to-back: a new req in the cycle after RESP is accepted normally.
- Read-after-write to the same address returns the new data: the write commits before any later read can sample.

Test Plan:
- Store then load, WAIT_CYCLES=2: store word 0xDEADBEEF @0x10; load word @0x10 → ready 3 cycles after acceptance, rdata=0xDEADBEEF, misalign=0.
- Byte and half extension: after the word store above:
  - lb @0x13 (se_s=0) → 0xFFFFFFDE.
  - lbu @0x13 (se_s=1) → 0x000000DE.
  - lh @0x12 → 0xFFFFDEAD.
  - lhu @0x10 → 0x0000BEEF.
- Partial store merge: sb 0x55 @0x11, then sh 0x1234 @0x12; lw @0x10 → 0x123455EF.
- Misalignment: lw @0x12, lh @0x11, size_s=11 @0x0 → each gives ready at T+1 with misalign=1, rdata=0; subsequent lw @0x10 still → 0x123455EF.
- Busy/wrap:
  - req pulsed during WAIT is ignored: exactly one ready.
  - With DEPTH_WORDS=256, sw 0xA5A5A5A5 @0x400; lw @0x0 → 0xA5A5A5A5.
- Reset mid-op: issue sw 0x11111111 @0x20 after sw 0x22222222 @0x20 completed; assert rst during WAIT → no ready. After reset, lw @0x20 → 0x22222222, and all outputs are 0 in the cycle after rst.
